// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its requester-side client.
package rr_arb_pkg;

  localparam int ARB_WIDTH = 4;
  localparam int CHW       = $clog2(ARB_WIDTH);

  typedef logic [ARB_WIDTH-1:0] req_vec_t;

  function automatic logic onehot0(input req_vec_t v);
    return (v & (v - req_vec_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/rr_chan_fifo.sv
// Per-channel DEPTH x DW synchronous FIFO with occupancy output.
module rr_chan_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rr_arb_client.sv
// Requester-side front end for the round-robin arbiter: per-channel FIFOs,
// request generation, grant consumption into a single valid/ready output.
module rr_arb_client
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    in_valid,
  output logic [WIDTH-1:0]    in_ready,
  input  logic [WIDTH*DW-1:0] in_data,
  output logic [WIDTH-1:0]    request,
  input  logic [WIDTH-1:0]    grant,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  output logic [CHW-1:0]      out_chan,
  input  logic                out_ready,
  output logic                err
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [DW-1:0]    head [WIDTH];
  logic [OW-1:0]    occ  [WIDTH];
  logic [WIDTH-1:0] full, empty, push, take;
  logic             stall, err_now, any_take;
  logic [DW-1:0]    sel_data;
  logic [CHW-1:0]   sel_chan;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    assign push[i] = in_valid[i] & ~full[i];

    rr_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[i]),
      .push_data (in_data[i*DW +: DW]),
      .pop       (take[i]),
      .head      (head[i]),
      .occ       (occ[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  assign in_ready = ~full;
  assign stall    = out_valid & ~out_ready;

  // A malformed grant blocks every pop that cycle; grants during a stall are dropped silently.
  assign err_now  = ~onehot0(grant) | (|(grant & empty & {WIDTH{~stall}}));
  assign take     = (err_now | stall) ? '0 : (grant & ~empty);
  assign any_take = |take;

  // Hide the entry being consumed so the arbiter cannot re-grant it next cycle.
  always_comb begin
    request = '0;
    for (int i = 0; i < WIDTH; i++) begin
      request[i] = ~stall & (take[i] ? (occ[i] > OW'(1)) : ~empty[i]);
    end
  end

  always_comb begin
    sel_data = '0;
    sel_chan = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (take[i]) begin
        sel_data = head[i];
        sel_chan = CHW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (any_take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_chan  <= sel_chan;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (err_now) err <= 1'b1;
  end

endmodule

// File: tb/tb_rr_arb_client.sv
// Directed bench for rr_arb_client with a small registered round-robin arbiter model attached.
module tb_rr_arb_client;
  import rr_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [31:0] in_data;
  logic [3:0]  request;
  logic [3:0]  grant;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;
  logic        err;

  logic        arb_en;
  logic [3:0]  man_grant;
  logic [3:0]  arb_grant, arb_next;
  logic [1:0]  arb_last;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arb_client #(.WIDTH(4), .DW(8), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .request   (request),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready),
    .err       (err)
  );

  // Reference arbiter: registered one-hot grant, rotating priority after the last winner.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [3:0] g;
    logic [1:0] j;
    g = '0;
    for (int k = 4; k >= 1; k--) begin
      j = 2'(int'(last) + k);
      if (req[j]) g = 4'b0001 << j;
    end
    return g;
  endfunction

  assign arb_next = arb_en ? rr_pick(request, arb_last) : 4'b0000;
  assign grant    = arb_en ? arb_grant : man_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_grant <= '0;
      arb_last  <= 2'd3;
    end else begin
      arb_grant <= arb_next;
      for (int k = 0; k < 4; k++) begin
        if (arb_next[k]) arb_last <= 2'(k);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input logic [1:0] ch, input logic [7:0] dt, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (out_valid && out_ready) begin
        chk({name, " chan"}, 32'(out_chan), 32'(ch));
        chk({name, " data"}, 32'(out_data), 32'(dt));
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout, got no output, expected chan %0d data %0h", name, ch, dt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    man_grant = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] id;
    logic [3:0]  gr;
    logic        ordy;
    logic [3:0]  req;
    logic [3:0]  ir;
    logic        ov;
    logic [1:0]  ch;
    logic [7:0]  dt;
    logic        er;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
    arb_en = 1'b0; man_grant = '0;

    // Manual grant sequence: one pop, a malformed grant, then an empty-channel grant after reset.
    tbl[0]  = '{1'b1, 4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 32'h00000011, 4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h1, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 32'h0,        4'h1, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 4'hF, 1'b1, 2'd0, 8'h11, 1'b0};
    tbl[5]  = '{1'b0, 4'h4, 32'h002A0000, 4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 32'h0,        4'h3, 1'b1, 4'h4, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h4, 4'hF, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[8]  = '{1'b0, 4'h0, 32'h0,        4'h4, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 4'hF, 1'b1, 2'd2, 8'h2A, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 32'h0,        4'h4, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 4'hF, 1'b0, 2'd0, 8'h00, 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int v = 0; v < 13; v++) begin
      @(posedge clk);
      #1;
      if (tbl[v].rst) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      in_valid  = tbl[v].iv;
      in_data   = tbl[v].id;
      man_grant = tbl[v].gr;
      out_ready = tbl[v].ordy;
      #3;
      chk($sformatf("vec%0d request", v),   32'(request),   32'(tbl[v].req));
      chk($sformatf("vec%0d in_ready", v),  32'(in_ready),  32'(tbl[v].ir));
      chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(tbl[v].ov));
      chk($sformatf("vec%0d err", v),       32'(err),       32'(tbl[v].er));
      if (tbl[v].ov) begin
        chk($sformatf("vec%0d out_chan", v), 32'(out_chan), 32'(tbl[v].ch));
        chk($sformatf("vec%0d out_data", v), 32'(out_data), 32'(tbl[v].dt));
      end
    end

    // Reset then idle, arbiter attached.
    arb_en = 1'b1;
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle request", 32'(request), 32'h0);
      chk("idle in_ready", 32'(in_ready), 32'hF);
      chk("idle out_valid", 32'(out_valid), 32'h0);
      chk("idle err", 32'(err), 32'h0);
    end

    // Single push on channel 2.
    in_valid = 4'b0100; in_data = 32'h00A50000;
    @(negedge clk);
    chk("single request", 32'(request), 32'h4);
    chk("single grant early", 32'(grant), 32'h0);
    in_valid = '0;
    @(negedge clk);
    chk("single grant", 32'(grant), 32'h4);
    chk("single request hidden", 32'(request), 32'h0);
    chk("single out_valid early", 32'(out_valid), 32'h0);
    @(negedge clk);
    chk("single out_valid", 32'(out_valid), 32'h1);
    chk("single out_chan", 32'(out_chan), 32'h2);
    chk("single out_data", 32'(out_data), 32'hA5);
    chk("single no regrant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("single drained", 32'(out_valid), 32'h0);
    chk("single request after", 32'(request), 32'h0);
    chk("single grant after", 32'(grant), 32'h0);

    // Fill all four channels with two entries each, drain in round-robin order.
    do_reset();
    in_valid = 4'hF; in_data = 32'h30201000;
    @(negedge clk);
    in_data = 32'h31211101;
    @(negedge clk);
    in_valid = '0;
    for (int k = 0; k < 8; k++) begin
      expect_out($sformatf("fill out%0d", k), 2'(k % 4), {4'(k % 4), 4'(k / 4)}, 10);
    end
    repeat (2) @(negedge clk);
    chk("fill in_ready", 32'(in_ready), 32'hF);
    chk("fill err", 32'(err), 32'h0);
    chk("fill idle", 32'(out_valid), 32'h0);

    // Backpressure with an in-flight grant on channel 1.
    out_ready = 1'b0;
    do_reset();
    in_valid = 4'b0011; in_data = 32'h00001B0A;
    @(negedge clk);
    in_valid = '0;
    chk("bp request", 32'(request), 32'h3);
    @(negedge clk);
    chk("bp grant0", 32'(grant), 32'h1);
    chk("bp request ch1", 32'(request), 32'h2);
    @(negedge clk);
    chk("bp inflight grant", 32'(grant), 32'h2);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("bp stall%0d out_valid", c), 32'(out_valid), 32'h1);
      chk($sformatf("bp stall%0d out_data", c), 32'(out_data), 32'h0A);
      chk($sformatf("bp stall%0d request", c), 32'(request), 32'h0);
      chk($sformatf("bp stall%0d err", c), 32'(err), 32'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp released out_valid", 32'(out_valid), 32'h0);
    chk("bp regrant", 32'(grant), 32'h2);
    @(negedge clk);
    chk("bp ch1 out_valid", 32'(out_valid), 32'h1);
    chk("bp ch1 out_chan", 32'(out_chan), 32'h1);
    chk("bp ch1 out_data", 32'(out_data), 32'h1B);
    @(negedge clk);
    chk("bp done out_valid", 32'(out_valid), 32'h0);
    chk("bp done request", 32'(request), 32'h0);
    chk("bp done err", 32'(err), 32'h0);

    // Full FIFO on channel 3 with the output stalled.
    out_ready = 1'b0;
    do_reset();
    in_valid = 4'b1000; in_data = 32'hC1000000;
    @(negedge clk);
    chk("full in_ready 1", 32'(in_ready), 32'hF);
    in_data = 32'hC2000000;
    @(negedge clk);
    chk("full in_ready 2", 32'(in_ready), 32'h7);
    chk("full grant", 32'(grant), 32'h8);
    in_data = 32'hC3000000;
    @(negedge clk);
    chk("full popped out_data", 32'(out_data), 32'hC1);
    chk("full in_ready reopen", 32'(in_ready), 32'hF);
    chk("full dropped grant", 32'(grant), 32'h8);
    @(negedge clk);
    chk("full third taken", 32'(in_ready), 32'h7);
    chk("full held out_data", 32'(out_data), 32'hC1);
    chk("full err", 32'(err), 32'h0);
    in_valid = '0;
    out_ready = 1'b1;
    expect_out("full out0", 2'd3, 8'hC1, 10);
    expect_out("full out1", 2'd3, 8'hC2, 10);
    expect_out("full out2", 2'd3, 8'hC3, 10);
    @(negedge clk);
    chk("full drained in_ready", 32'(in_ready), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
